redstone_repeater_elastic: RTL and testbench
============================================

Name: redstone_repeater_elastic

Overview:
Parametrised successor to the single-register stream repeater. Carries REGISTER_SIZE-bit chunks of BITS_IN_NUM-bit numbers across long routes through STAGES retiming registers. An output FIFO absorbs downstream backpressure through request_next_input. Credit-based upstream flow control (ready_out) guarantees no chunk is lost or reordered. It also tags the final chunk of each number, so consumers can frame multi-chunk operands.

Parameters:
BITS_IN_NUM, 4096, bits per number; CHUNKS = ceil(BITS_IN_NUM/REGISTER_SIZE).
REGISTER_SIZE, 64, bits per chunk (data width).
STAGES, 2, retiming register stages before the FIFO; legal range >= 1.
FIFO_DEPTH, 8, output FIFO entries; legal range >= 1; full throughput requires FIFO_DEPTH >= STAGES+1.

Ports:
clk_in  input  1  clock; all logic on rising edge.
rst_in  input  1  synchronous, active-low reset (rst_in==0 resets on the clock edge).
data_in  input  REGISTER_SIZE  chunk from upstream.
data_valid_in  input  1  chunk present on data_in.
ready_out  output  1  upstream may present a chunk this cycle.
request_next_input  input  1  downstream consumes the current output chunk.
data_out  output  REGISTER_SIZE  FIFO head chunk.
data_valid_out  output  1  data_out holds a valid chunk (FIFO not empty).
last_chunk_out  output  1  data_out is chunk CHUNKS-1 of its number.
count_out  output  $clog2(FIFO_DEPTH+1)  chunks in flight (stages plus FIFO).
overflow_out  output  1  sticky; a chunk was presented while ready_out was low.

Behaviour:
- Reset (rst_in==0): all stage valids, FIFO pointers, count_out, chunk index and overflow_out go to 0; data_out reads 0; data_valid_out=0; last_chunk_out=0; ready_out=1 in the first cycle after reset. Mid-stream reset discards all in-flight data.
- Accept: data_valid_in && ready_out. A chunk accepted at edge k enters stage 1, shifts one stage per edge, and is written to the FIFO at edge k+STAGES. With the FIFO empty, data_valid_out rises in the cycle after edge k+STAGES. Latency is therefore STAGES+1 cycles from presentation.
- Stages never stall; the credit scheme guarantees the FIFO has room on arrival.
- Pop: data_valid_out && request_next_input, taken at the clock edge. The FIFO is first-word-fall-through: the next entry appears the following cycle. request_next_input while data_valid_out=0 is ignored.
- count_out register update:
  - +1 on accept, -1 on pop.
  - Simultaneous accept and pop leaves it unchanged.
  - Never exceeds FIFO_DEPTH.
- ready_out = (count_out < FIFO_DEPTH), decoded from registers only. There is no combinational path from request_next_input or data_valid_in to ready_out.
- Overflow: data_valid_in && !ready_out drops the chunk, sets overflow_out (cleared only by reset), and leaves count_out unchanged.
- Throughput: min(1, FIFO_DEPTH/(STAGES+1)) chunks per cycle under continuous request.
- Chunk index: counts pops modulo CHUNKS and wraps CHUNKS-1 to 0.
  - last_chunk_out = data_valid_out && (index == CHUNKS-1).
  - When CHUNKS==1, every valid chunk is last.
- Ordering: output order equals accept order; no duplication.
- FIFO pointers wrap modulo FIFO_DEPTH. A non-power-of-2 FIFO_DEPTH must be supported.

Test Plan:
1. Reset: hold rst_in=0 for 3 cycles with data_valid_in=1 -> data_valid_out=0, count_out=0, overflow_out=0. Release -> ready_out=1.
2. Single chunk, STAGES=2: present 0xA5 in cycle 0 with request_next_input=1 -> data_out=0xA5 and data_valid_out=1 in cycle 3 only; count_out returns to 0.
3. Streaming, STAGES=2, FIFO_DEPTH=8, request_next_input held 1, 64 back-to-back chunks 0..63 -> ready_out never drops; outputs 0..63 in order on consecutive cycles.
4. Backpressure: request_next_input=0 while streaming -> ready_out drops after exactly 8 accepts; count_out=8; no drops. Raising request_next_input drains the FIFO in order, and ready_out returns 1 the cycle after the first pop.
5. Overflow: with ready_out=0, present 0xDEAD -> chunk never emerges; overflow_out=1 and stays 1 until reset; count_out unchanged.
6. Framing and mid-reset: BITS_IN_NUM=256, REGISTER_SIZE=64 -> last_chunk_out on output chunks 3, 7, 11. Assert reset after 5 accepts -> outputs cleared; the following stream restarts with index 0.

Source files
------------

// File: rtl/redstone_repeater_elastic.sv
// Elastic stream repeater: retiming stages feeding a FWFT output FIFO.
// Credit-based ready_out, sticky overflow flag and last-chunk framing.
module redstone_repeater_elastic #(
    parameter int BITS_IN_NUM   = 4096,
    parameter int REGISTER_SIZE = 64,
    parameter int STAGES        = 2,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [REGISTER_SIZE-1:0]         data_in,
    input  logic                             data_valid_in,
    output logic                             ready_out,
    input  logic                             request_next_input,
    output logic [REGISTER_SIZE-1:0]         data_out,
    output logic                             data_valid_out,
    output logic                             last_chunk_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_out,
    output logic                             overflow_out
);

    localparam int CHUNKS = (BITS_IN_NUM + REGISTER_SIZE - 1) / REGISTER_SIZE;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    logic [STAGES-1:0]        sv_q;
    logic [REGISTER_SIZE-1:0] sd_q  [STAGES];
    logic [REGISTER_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]            wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]            fcnt_q, fcnt_d, cnt_q, cnt_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic                     ovf_q, ovf_d;

    logic accept, push, pop, fvalid;

    // Credits cover stages plus FIFO, so ready_out depends on registers only
    assign ready_out = (cnt_q < DEPTH_C);
    assign accept    = data_valid_in && ready_out;
    assign fvalid    = (fcnt_q != '0);
    assign pop       = fvalid && request_next_input;
    assign push      = sv_q[STAGES-1];

    assign data_valid_out = fvalid;
    assign data_out       = fvalid ? mem_q[rd_q] : '0;
    assign last_chunk_out = fvalid && (idx_q == LAST_IDX);
    assign count_out      = cnt_q;
    assign overflow_out   = ovf_q;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        fcnt_d = fcnt_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        ovf_d  = ovf_q;
        if (push) wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
        if (pop) begin
            rd_d  = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        if (push && !pop) fcnt_d = fcnt_q + 1'b1;
        if (!push && pop) fcnt_d = fcnt_q - 1'b1;
        if (accept && !pop) cnt_d = cnt_q + 1'b1;
        if (!accept && pop) cnt_d = cnt_q - 1'b1;
        if (data_valid_in && !ready_out) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sv_q   <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sv_q[0] <= accept;
            for (int i = 1; i < STAGES; i++) sv_q[i] <= sv_q[i-1];
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fcnt_q <= fcnt_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            ovf_q  <= ovf_d;
        end
    end

    // Payload registers carry no reset; validity is tracked separately
    always_ff @(posedge clk_in) begin
        sd_q[0] <= data_in;
        for (int i = 1; i < STAGES; i++) sd_q[i] <= sd_q[i-1];
        if (push) mem_q[wr_q] <= sd_q[STAGES-1];
    end

endmodule

// File: tb/tb_redstone_repeater_elastic.sv
// Scoreboard bench for redstone_repeater_elastic: a queue of accepted
// chunks with arrival cycles predicts valid, data, framing and credits.
module tb_redstone_repeater_elastic;

    localparam int BITS   = 256;
    localparam int RS     = 64;
    localparam int STG    = 2;
    localparam int DEPTH  = 8;
    localparam int CHUNKS = (BITS + RS - 1) / RS;
    localparam int CW     = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RS-1:0] data_in;
    logic          dv_in;
    logic          ready;
    logic          req;
    logic [RS-1:0] data_out;
    logic          dv_out;
    logic          last;
    logic [CW-1:0] count;
    logic          ovf;

    redstone_repeater_elastic #(
        .BITS_IN_NUM  (BITS),
        .REGISTER_SIZE(RS),
        .STAGES       (STG),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .data_in           (data_in),
        .data_valid_in     (dv_in),
        .ready_out         (ready),
        .request_next_input(req),
        .data_out          (data_out),
        .data_valid_out    (dv_out),
        .last_chunk_out    (last),
        .count_out         (count),
        .overflow_out      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RS-1:0] d;
        bit            lst;
        int            avail;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   acc_idx = 0;
    bit   movf    = 0;
    bit   mon_on  = 0;
    int   errors  = 0;
    int   checks  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: compares outputs with the model, then advances the model
    // by what the coming edge does.
    always @(negedge clk) begin
        if (mon_on) begin
            bit   ev, pop, acc, mready;
            exp_t e;
            cyc++;
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            chk("valid", 64'(dv_out), 64'(ev));
            chk("count", 64'(count), 64'(q.size()));
            chk("ready", 64'(ready), 64'(q.size() < DEPTH));
            chk("overflow", 64'(ovf), 64'(movf));
            if (ev) begin
                chk("data", data_out, q[0].d);
                chk("last", 64'(last), 64'(q[0].lst));
            end else begin
                chk("last_idle", 64'(last), 64'(0));
            end
            if (!rst_n) begin
                q.delete();
                acc_idx = 0;
                movf = 0;
            end else begin
                mready = (q.size() < DEPTH);
                pop = ev && req;
                acc = dv_in && mready;
                if (dv_in && !mready) movf = 1;
                if (pop) void'(q.pop_front());
                if (acc) begin
                    e.d = data_in;
                    e.lst = (acc_idx == CHUNKS - 1);
                    e.avail = cyc + STG + 1;
                    q.push_back(e);
                    acc_idx = (acc_idx + 1) % CHUNKS;
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [RS-1:0] d, input bit r);
        dv_in = v;
        data_in = d;
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        dv_in = 1'b1;
        data_in = 64'h1234;
        req = 1'b0;
        @(posedge clk);
        #1;
        mon_on = 1;
        drive(1, 64'h1234, 0);
        drive(1, 64'h1234, 0);
        rst_n = 1'b1;

        // single chunk
        drive(1, 64'hA5, 1);
        repeat (6) drive(0, 64'h0, 1);

        // back-to-back streaming
        for (int i = 0; i < 64; i++) drive(1, 64'(i), 1);
        repeat (6) drive(0, 64'h0, 1);

        // backpressure: fill exactly to the credit limit
        for (int i = 0; i < DEPTH; i++) drive(1, 64'h100 + 64'(i), 0);
        repeat (4) drive(0, 64'h0, 0);
        // overflow attempt while full
        drive(1, 64'hDEAD, 0);
        repeat (2) drive(0, 64'h0, 0);
        repeat (12) drive(0, 64'h0, 1);

        // randomized traffic, biased to reach full regularly
        for (int i = 0; i < 400; i++) begin
            bit v, r;
            v = ($urandom_range(3) != 0);
            r = ((i / 50) % 2 == 0) ? ($urandom_range(3) != 0)
                                    : ($urandom_range(3) == 0);
            drive(v, {$urandom, $urandom}, r);
        end
        repeat (16) drive(0, 64'h0, 1);

        // mid-stream reset after five accepts
        for (int i = 0; i < 5; i++) drive(1, 64'h200 + 64'(i), 0);
        rst_n = 1'b0;
        drive(1, 64'hBAD, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) drive(1, 64'h300 + 64'(i), 1);
        repeat (16) drive(0, 64'h0, 1);

        chk("final_count", 64'(count), 64'(0));
        chk("final_valid", 64'(dv_out), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
